// File: rtl/alu_result_stage.sv
// EX/MEM result stage for the 64-bit ALU: registers the selected result and writeback control, and holds NZVC.
// Optional macro FLAG_BYPASS_EN forwards flags being written this cycle straight onto br_*.
module alu_result_stage #(
    parameter int WIDTH    = 64,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    alu_result,
    input  logic                alu_carry,
    input  logic                alu_overflow,
    input  logic                ex_valid,
    input  logic                set_flags,
    input  logic                ex_reg_write,
    input  logic [REG_BITS-1:0] ex_dest,
    input  logic                stall,
    input  logic                flush,
    output logic [WIDTH-1:0]    mem_result,
    output logic [REG_BITS-1:0] mem_dest,
    output logic                mem_reg_write,
    output logic                mem_valid,
    output logic                flag_n,
    output logic                flag_z,
    output logic                flag_v,
    output logic                flag_c,
    output logic                br_n,
    output logic                br_z,
    output logic                br_v,
    output logic                br_c,
    output logic                ex_zero
);

    logic [WIDTH-1:0]    result_q, result_d;
    logic [REG_BITS-1:0] dest_q, dest_d;
    logic                valid_q, valid_d;
    logic                reg_write_q, reg_write_d;
    logic [3:0]          nzvc_q, nzvc_d;
    logic [3:0]          nzvc_new;
    logic                flag_update;

    assign ex_zero     = ~|alu_result;
    assign nzvc_new    = {alu_result[WIDTH-1], ex_zero, alu_overflow, alu_carry};
    assign flag_update = ex_valid & set_flags & ~stall & ~flush;

    // Priority flush > stall > load; flush keeps result/dest so they stay deterministic.
    always_comb begin
        result_d    = result_q;
        dest_d      = dest_q;
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (!stall) begin
            result_d    = alu_result;
            dest_d      = ex_dest;
            valid_d     = ex_valid;
            reg_write_d = ex_reg_write & ex_valid;
        end
    end

    always_comb begin
        nzvc_d = nzvc_q;
        if (flag_update) begin
            nzvc_d = nzvc_new;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q    <= '0;
            dest_q      <= '0;
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            nzvc_q      <= 4'b0000;
        end else begin
            result_q    <= result_d;
            dest_q      <= dest_d;
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            nzvc_q      <= nzvc_d;
        end
    end

    assign mem_result    = result_q;
    assign mem_dest      = dest_q;
    assign mem_valid     = valid_q;
    assign mem_reg_write = reg_write_q;
    assign {flag_n, flag_z, flag_v, flag_c} = nzvc_q;

`ifdef FLAG_BYPASS_EN
    // Same-cycle forwarding lets a B.cond right behind a flag setter resolve without a bubble.
    assign {br_n, br_z, br_v, br_c} = flag_update ? nzvc_new : nzvc_q;
`else
    assign {br_n, br_z, br_v, br_c} = nzvc_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed cases from the plan plus random traffic,
// checked through an expected queue against a per-cycle reference model.
module tb_alu_result_stage;

    localparam int WIDTH    = 64;
    localparam int REG_BITS = 5;
    localparam int EW       = WIDTH + REG_BITS + 2 + 4;

    logic                clk;
    logic                reset;
    logic [WIDTH-1:0]    alu_result;
    logic                alu_carry;
    logic                alu_overflow;
    logic                ex_valid;
    logic                set_flags;
    logic                ex_reg_write;
    logic [REG_BITS-1:0] ex_dest;
    logic                stall;
    logic                flush;
    logic [WIDTH-1:0]    mem_result;
    logic [REG_BITS-1:0] mem_dest;
    logic                mem_reg_write;
    logic                mem_valid;
    logic                flag_n, flag_z, flag_v, flag_c;
    logic                br_n, br_z, br_v, br_c;
    logic                ex_zero;

    int total = 0;
    int bad   = 0;

    logic [EW-1:0] exp_q[$];

    // reference state
    logic [WIDTH-1:0]    m_result;
    logic [REG_BITS-1:0] m_dest;
    logic                m_valid;
    logic                m_rw;
    logic [3:0]          m_flags;

    alu_result_stage #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) dut (
        .clk(clk), .reset(reset),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .ex_valid(ex_valid), .set_flags(set_flags), .ex_reg_write(ex_reg_write),
        .ex_dest(ex_dest), .stall(stall), .flush(flush),
        .mem_result(mem_result), .mem_dest(mem_dest),
        .mem_reg_write(mem_reg_write), .mem_valid(mem_valid),
        .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c),
        .br_n(br_n), .br_z(br_z), .br_v(br_v), .br_c(br_c),
        .ex_zero(ex_zero)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack_model();
        return {m_result, m_dest, m_valid, m_rw, m_flags};
    endfunction

    task automatic model_reset();
        m_result = '0;
        m_dest   = '0;
        m_valid  = 1'b0;
        m_rw     = 1'b0;
        m_flags  = 4'b0000;
    endtask

    // Called at a negedge: applies inputs, checks combinational outputs,
    // advances the model, queues the post-edge expectation, waits for next negedge.
    task automatic drive(input logic [WIDTH-1:0] res, input logic cy, input logic ov,
                         input logic v, input logic sf, input logic rw,
                         input logic [REG_BITS-1:0] dst, input logic st, input logic fl);
        logic       upd;
        logic [3:0] written;
        logic [3:0] exp_br;
        alu_result = res; alu_carry = cy; alu_overflow = ov;
        ex_valid = v; set_flags = sf; ex_reg_write = rw; ex_dest = dst;
        stall = st; flush = fl;
        #1;
        upd     = v && sf && !st && !fl;
        written = {res[WIDTH-1], (res == 0), ov, cy};
        check("ex_zero", {127'd0, ex_zero}, {127'd0, res == 0});
`ifdef FLAG_BYPASS_EN
        exp_br = upd ? written : m_flags;
`else
        exp_br = m_flags;
`endif
        check("br_nzvc", {124'd0, br_n, br_z, br_v, br_c}, {124'd0, exp_br});
        if (fl) begin
            m_valid = 1'b0;
            m_rw    = 1'b0;
        end else if (!st) begin
            m_result = res;
            m_dest   = dst;
            m_valid  = v;
            m_rw     = v && rw;
        end
        if (upd) m_flags = written;
        exp_q.push_back(pack_model());
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_mem"}, {mem_result, mem_dest, mem_valid, mem_reg_write}, '0);
        check({name, "_flags"}, {flag_n, flag_z, flag_v, flag_c, br_n, br_z, br_v, br_c}, '0);
    endtask

    // monitor: one expected entry per edge after a drive
    always @(posedge clk) begin
        #1;
        if (!reset && exp_q.size() > 0) begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("mem_and_flags",
                  {mem_result, mem_dest, mem_valid, mem_reg_write, flag_n, flag_z, flag_v, flag_c}, e);
            if (mem_reg_write && !mem_valid) begin
                total++; bad++;
                $display("FAIL rw_without_valid: rw=%b valid=%b", mem_reg_write, mem_valid);
            end
        end
    end

    initial begin
        reset = 1'b1;
        alu_result = '0; alu_carry = 0; alu_overflow = 0; ex_valid = 0;
        set_flags = 0; ex_reg_write = 0; ex_dest = '0; stall = 0; flush = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b0;

        // basic load: NZVC=1001
        drive(64'h8000_0000_0000_0000, 1, 0, 1, 1, 1, 5'd3, 0, 0);
        // zero result: NZVC=0110
        drive(64'h0, 0, 1, 1, 1, 1, 5'd7, 0, 0);
        // zero result without set_flags: flags hold
        drive(64'h0, 1, 0, 1, 0, 0, 5'd9, 0, 0);
        // establish NZVC=0100
        drive(64'h0, 0, 0, 1, 1, 1, 5'd2, 0, 0);
        // stall + flush together
        drive(64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 1, 1, 1, 5'd31, 1, 1);
        // reload, then stall alone holds everything
        drive(64'h1234_5678_9ABC_DEF0, 0, 0, 1, 0, 1, 5'd12, 0, 0);
        drive(64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 1, 1, 1, 5'd30, 1, 0);
        // invalid instruction
        drive(64'h8000_0000_0000_0001, 1, 1, 0, 1, 1, 5'd4, 0, 0);
        // NZVC=1000 for the bypass case, followed by a flag-neutral cycle
        drive(64'h8000_0000_0000_0000, 0, 0, 1, 1, 0, 5'd5, 0, 0);
        drive(64'h5, 0, 0, 1, 0, 0, 5'd6, 0, 0);
        // loaded state with V and C set, then asynchronous reset between edges
        drive(64'h8000_0000_0000_0000, 1, 1, 1, 1, 1, 5'd17, 0, 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        // first edge after release is a normal load
        drive(64'hDEAD_BEEF_0000_0001, 1, 0, 1, 1, 1, 5'd21, 0, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [WIDTH-1:0] r;
            r = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) r = '0;
            drive(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), REG_BITS'($urandom_range(0, 31)),
                  1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0));
        end

        @(posedge clk);
        #3;
        check("queue_drained", {96'd0, 32'(exp_q.size())}, 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
